laser_cover_scorer: RTL
=======================

// Module: laser_cover_scorer
// PURPOSE
//  Downstream checker for the two-circle laser placement stage. Snoops the same 40-point X/Y
//  stream the placement stage captures after reset, then, when DONE rises, latches C1/C2 and
//  rescans the stored points one per cycle. Reports per-circle and union coverage counts on
//  a valid/ready result port, for on-chip self-check and host readback.
// PARAMETERS
//  NUM_POINTS  40  points captured after reset (counter widths fixed for <=63)
//  RADIUS_SQ   16  point covered iff dx*dx+dy*dy <= RADIUS_SQ (radius 4, integer grid)
// PORTS
//  CLK          in   1  clock, all state on rising edge
//  RST          in   1  asynchronous, active-high reset
//  X            in   4  point x, one point per cycle, shared with placement stage input
//  Y            in   4  point y, same timing as X
//  C1X,C1Y      in   4  circle-1 centre from placement stage
//  C2X,C2Y      in   4  circle-2 centre from placement stage
//  DONE         in   1  placement-stage done; centres valid while high
//  SCORE        out  6  points covered by circle 1 OR circle 2
//  CNT1         out  6  points covered by circle 1
//  CNT2         out  6  points covered by circle 2
//  SCORE_VALID  out  1  result valid; held until accepted
//  SCORE_READY  in   1  consumer accepts result at rising edge when SCORE_VALID=1
//  BUSY         out  1  high in CAPTURE, WAIT_DONE and SCAN
// BEHAVIOUR
//  Reset: SCORE=CNT1=CNT2=0, SCORE_VALID=0, BUSY=1, state CAPTURE, index=0, point RAM contents
//   don't-care (never read before rewritten).
//  States: CAPTURE -> WAIT_DONE -> SCAN -> REPORT -> IDLE. IDLE is terminal until next RST.
//  CAPTURE: first rising edge with RST low stores X/Y as point 0; edge k stores point k;
//   after point NUM_POINTS-1 go to WAIT_DONE. DONE is ignored in CAPTURE.
//  WAIT_DONE: on the first edge with DONE=1, latch C1X..C2Y, clear counts, index=0, go to SCAN.
//  SCAN: one point per cycle. dx=|px-cx| and dy=|py-cy| are 4-bit unsigned.
//   Squares are 8-bit, and the sum is 9-bit, so no overflow is possible.
//   Compare with <= (boundary inclusive). Per point: in1 -> CNT1+1, in2 -> CNT2+1,
//   in1|in2 -> SCORE+1. A point inside both circles adds 1 to SCORE, not 2.
//  Latency: if DONE is sampled high at edge t, point k is evaluated in cycle t+1+k.
//   SCORE_VALID rises at edge t+NUM_POINTS+1 with final counts.
//  Counts stay internal during SCAN; output ports update only on entry to REPORT,
//   so no partial counts are visible.
//  REPORT: SCORE_VALID=1, and SCORE/CNT1/CNT2 hold stable until an edge with SCORE_READY=1.
//   READY high in the first REPORT cycle completes the transfer that cycle.
//   After the transfer: SCORE_VALID=0 next cycle, enter IDLE, and counts stay on the ports.
//  DONE dropping during SCAN/REPORT has no effect, because centres are already latched.
//   DONE high again in IDLE is ignored.
//  BUSY=0 only in REPORT and IDLE.
//  RST asserted in any state, including mid-SCAN or mid-REPORT:
//   - immediately returns outputs to reset values;
//   - capture restarts at point 0 on the first edge after release.
// TESTING
//  1 All 40 points (5,5), C1=C2=(5,5), DONE at edge 45 -> SCORE_VALID rises edge 86;
//    SCORE=CNT1=CNT2=40.
//  2 20 pts (0,0) and 20 pts (15,15), C1=(0,0), C2=(15,15) -> CNT1=20, CNT2=20, SCORE=40.
//  3 Boundary, C1=(0,0), C2=(15,0): pts (4,0),(0,4),(3,2),(2,3) count;
//    (3,3),(4,1),(1,4),(5,0) do not; other 32 pts at (8,15) -> CNT1=4, CNT2=0, SCORE=4.
//  4 Backpressure: hold SCORE_READY=0 for 10 cycles after SCORE_VALID ->
//    VALID stays 1 and counts stay stable; READY=1 -> VALID=0 next cycle; later READY is ignored.
//  5 DONE pulsed at edge 10 (during CAPTURE) and again at edge 50 ->
//    scan starts only from edge 50; SCORE_VALID at edge 91.
//  6 RST pulsed at SCAN point 20 -> outputs zero, BUSY=1;
//    a new 40-pt stream plus DONE gives the correct counts for the new set only.

Source files
------------

// File: rtl/laser_cover_scorer_if.sv
`default_nettype none
// ============================================================================
// Module   : laser_cover_scorer_if
// Purpose  : Point stream, circle centres and scored result port of the scorer.
// Revision : 1.0
// ============================================================================
interface laser_cover_scorer_if;
  logic [3:0] x_i;
  logic [3:0] y_i;
  logic [3:0] c1x_i;
  logic [3:0] c1y_i;
  logic [3:0] c2x_i;
  logic [3:0] c2y_i;
  logic       done_i;
  logic [5:0] score_o;
  logic [5:0] cnt1_o;
  logic [5:0] cnt2_o;
  logic       score_valid_o;
  logic       score_ready_i;
  logic       busy_o;

  modport master (
    output x_i, y_i, c1x_i, c1y_i, c2x_i, c2y_i, done_i, score_ready_i,
    input  score_o, cnt1_o, cnt2_o, score_valid_o, busy_o
  );

  modport slave (
    input  x_i, y_i, c1x_i, c1y_i, c2x_i, c2y_i, done_i, score_ready_i,
    output score_o, cnt1_o, cnt2_o, score_valid_o, busy_o
  );
endinterface
`default_nettype wire

// File: rtl/laser_cover_scorer.sv
`default_nettype none
// ============================================================================
// Module   : laser_cover_scorer
// Purpose  : Captures the point stream, rescans it against two latched circles
//            and reports per-circle and union coverage counts on valid/ready.
// Revision : 1.0
// ============================================================================
module laser_cover_scorer #(
  parameter int NUM_POINTS = 40,
  parameter int RADIUS_SQ  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  laser_cover_scorer_if.slave  bus_io
);

  typedef enum logic [2:0] {
    S_CAPTURE   = 3'd0,
    S_WAIT_DONE = 3'd1,
    S_SCAN      = 3'd2,
    S_REPORT    = 3'd3,
    S_IDLE      = 3'd4
  } state_t;

  localparam logic [5:0] c_last = 6'(NUM_POINTS - 1);
  localparam logic [5:0] c_num  = 6'(NUM_POINTS);
  localparam logic [8:0] c_rsq  = 9'(RADIUS_SQ);

  state_t     state_q, state_d;
  logic [5:0] idx_q, idx_d;
  logic [3:0] c1x_q, c1x_d, c1y_q, c1y_d, c2x_q, c2x_d, c2y_q, c2y_d;
  logic [5:0] acc1_q, acc1_d, acc2_q, acc2_d, accu_q, accu_d;
  logic [5:0] score_q, score_d, cnt1_q, cnt1_d, cnt2_q, cnt2_d;
  logic       valid_q, valid_d;

  logic [3:0] ram_x_q [NUM_POINTS];
  logic [3:0] ram_y_q [NUM_POINTS];

  logic [3:0] w_px, w_py;
  logic       w_in1, w_in2;

  function automatic logic in_circle(input logic [3:0] px, input logic [3:0] py,
                                     input logic [3:0] cx, input logic [3:0] cy);
    logic [3:0] dx, dy;
    logic [7:0] sqx, sqy;
    logic [8:0] sum;
    dx  = (px >= cx) ? (px - cx) : (cx - px);
    dy  = (py >= cy) ? (py - cy) : (cy - py);
    sqx = {4'b0, dx} * {4'b0, dx};
    sqy = {4'b0, dy} * {4'b0, dy};
    sum = {1'b0, sqx} + {1'b0, sqy};
    return (sum <= c_rsq);
  endfunction

  // Point storage has no reset: every slot is rewritten in CAPTURE before SCAN reads it.
  always_ff @(posedge clk) begin
    if (state_q == S_CAPTURE) begin
      ram_x_q[idx_q] <= bus_io.x_i;
      ram_y_q[idx_q] <= bus_io.y_i;
    end
  end

  assign w_px  = ram_x_q[idx_q];
  assign w_py  = ram_y_q[idx_q];
  assign w_in1 = in_circle(w_px, w_py, c1x_q, c1y_q);
  assign w_in2 = in_circle(w_px, w_py, c2x_q, c2y_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_CAPTURE;
      idx_q   <= '0;
      c1x_q   <= '0;
      c1y_q   <= '0;
      c2x_q   <= '0;
      c2y_q   <= '0;
      acc1_q  <= '0;
      acc2_q  <= '0;
      accu_q  <= '0;
      score_q <= '0;
      cnt1_q  <= '0;
      cnt2_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      c1x_q   <= c1x_d;
      c1y_q   <= c1y_d;
      c2x_q   <= c2x_d;
      c2y_q   <= c2y_d;
      acc1_q  <= acc1_d;
      acc2_q  <= acc2_d;
      accu_q  <= accu_d;
      score_q <= score_d;
      cnt1_q  <= cnt1_d;
      cnt2_q  <= cnt2_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    c1x_d   = c1x_q;
    c1y_d   = c1y_q;
    c2x_d   = c2x_q;
    c2y_d   = c2y_q;
    acc1_d  = acc1_q;
    acc2_d  = acc2_q;
    accu_d  = accu_q;
    score_d = score_q;
    cnt1_d  = cnt1_q;
    cnt2_d  = cnt2_q;
    valid_d = valid_q;

    case (state_q)
      S_CAPTURE: begin
        if (idx_q == c_last) begin
          idx_d   = '0;
          state_d = S_WAIT_DONE;
        end else begin
          idx_d = idx_q + 6'd1;
        end
      end
      S_WAIT_DONE: begin
        if (bus_io.done_i) begin
          c1x_d   = bus_io.c1x_i;
          c1y_d   = bus_io.c1y_i;
          c2x_d   = bus_io.c2x_i;
          c2y_d   = bus_io.c2y_i;
          acc1_d  = '0;
          acc2_d  = '0;
          accu_d  = '0;
          idx_d   = '0;
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
        // One extra cycle after the last point publishes the finished counts.
        if (idx_q < c_num) begin
          acc1_d = acc1_q + {5'b0, w_in1};
          acc2_d = acc2_q + {5'b0, w_in2};
          accu_d = accu_q + {5'b0, (w_in1 | w_in2)};
          idx_d  = idx_q + 6'd1;
        end else begin
          score_d = accu_q;
          cnt1_d  = acc1_q;
          cnt2_d  = acc2_q;
          valid_d = 1'b1;
          state_d = S_REPORT;
        end
      end
      S_REPORT: begin
        if (bus_io.score_ready_i) begin
          valid_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      S_IDLE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_CAPTURE;
      end
    endcase
  end

  assign bus_io.score_o       = score_q;
  assign bus_io.cnt1_o        = cnt1_q;
  assign bus_io.cnt2_o        = cnt2_q;
  assign bus_io.score_valid_o = valid_q;
  assign bus_io.busy_o        = (state_q == S_CAPTURE) || (state_q == S_WAIT_DONE) ||
                                (state_q == S_SCAN);

endmodule
`default_nettype wire
